hazard_md_unit: RTL and testbench

- Next-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps Tuse/Tnew stall and forwarding control, with register-address and timing widths as parameters.
- Adds an internal busy tracker for the multi-cycle mult/div unit, an E-stage flush output and a saturating stall-cycle counter.

---
 rtl/hazard_md_unit.sv | 181 ++++++++++++++++++
 tb/tb_hazard_md_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_md_unit.sv
// Hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
// Resolves Tuse/Tnew data hazards by stalling D and bubbling E, selects
// forwarding paths into D and E, tracks the multi-cycle mult/div unit so
// that md-dependent instructions wait in D, and keeps a saturating count
// of stalled cycles.
module hazard_md_unit #(
    parameter int REG_AW   = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    // D stage
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [TW-1:0]     Tuse_rsD,
    input  logic [TW-1:0]     Tuse_rtD,
    input  logic              mdD,
    // E stage
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeRegE,
    input  logic              regWriteE,
    input  logic [TW-1:0]     TnewE,
    input  logic              mdStartE,
    input  logic              mdIsDivE,
    // M stage
    input  logic [REG_AW-1:0] writeRegM,
    input  logic              regWriteM,
    input  logic [TW-1:0]     TnewM,
    // W stage
    input  logic [REG_AW-1:0] writeRegW,
    input  logic              regWriteW,
    // controls
    output logic              stall,
    output logic              flushE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              mdBusy,
    output logic [CNT_W-1:0]  stallCount
);

    // The busy counter must hold the longer of the two latencies.
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int MD_CW   = $clog2(MAX_LAT + 1);

    localparam logic [MD_CW-1:0] MULT_LOAD = MD_CW'(MULT_LAT);
    localparam logic [MD_CW-1:0] DIV_LOAD  = MD_CW'(DIV_LAT);

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    logic [MD_CW-1:0] md_cnt_q;
    logic [MD_CW-1:0] md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic data_stall_rs;
    logic data_stall_rt;
    logic md_stall;
    logic stall_int;

    // A producer can supply a value only once its result is ready (Tnew == 0);
    // register 0 is hardwired and never matches a producer.
    function automatic logic m_ready_match(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] wreg,
        input logic              wen,
        input logic [TW-1:0]     tnew
    );
        return (src != '0) && (src == wreg) && wen && (tnew == '0);
    endfunction

    // E operand select: M result beats W result, which beats the register file.
    function automatic logic [1:0] fwd_sel_e(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] wreg_m,
        input logic              wen_m,
        input logic [TW-1:0]     tnew_m,
        input logic [REG_AW-1:0] wreg_w,
        input logic              wen_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (m_ready_match(src, wreg_m, wen_m, tnew_m)) begin
            sel = FWD_M;
        end else if ((src != '0) && (src == wreg_w) && wen_w) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    // A source must wait when an in-flight producer will not have its value
    // ready by the time the consumer needs it (Tuse < Tnew).
    function automatic logic src_hazard(
        input logic [REG_AW-1:0] src,
        input logic [TW-1:0]     tuse,
        input logic [REG_AW-1:0] wreg_e,
        input logic              wen_e,
        input logic [TW-1:0]     tnew_e,
        input logic [REG_AW-1:0] wreg_m,
        input logic              wen_m,
        input logic [TW-1:0]     tnew_m
    );
        logic hz_e;
        logic hz_m;
        hz_e = (src != '0) && (src == wreg_e) && wen_e && (tuse < tnew_e);
        hz_m = (src != '0) && (src == wreg_m) && wen_m && (tuse < tnew_m);
        return hz_e || hz_m;
    endfunction

    // Forwarding selects for the E-stage ALU operands and the D-stage compare.
    always_comb begin
        forwardAE = fwd_sel_e(rsE, writeRegM, regWriteM, TnewM, writeRegW, regWriteW);
        forwardBE = fwd_sel_e(rtE, writeRegM, regWriteM, TnewM, writeRegW, regWriteW);
        forwardAD = m_ready_match(rsD, writeRegM, regWriteM, TnewM);
        forwardBD = m_ready_match(rtD, writeRegM, regWriteM, TnewM);
    end

    // Stall decision: data hazard on either source, or an md access while the
    // md unit is busy or being started by the instruction right ahead.
    always_comb begin
        data_stall_rs = src_hazard(rsD, Tuse_rsD, writeRegE, regWriteE, TnewE,
                                   writeRegM, regWriteM, TnewM);
        data_stall_rt = src_hazard(rtD, Tuse_rtD, writeRegE, regWriteE, TnewE,
                                   writeRegM, regWriteM, TnewM);
        md_stall      = mdD && (mdBusy || mdStartE);
        stall_int     = data_stall_rs || data_stall_rt || md_stall;
    end

    assign stall  = stall_int;
    // The stalled D instruction must not also advance into E.
    assign flushE = stall_int;

    // Busy counter next state: a new issue reloads (latest issue wins),
    // otherwise count down to idle.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (mdStartE) begin
            md_cnt_d = mdIsDivE ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_CW'(1);
        end
    end

    // Busy counter register; reset clears it at once so mdBusy drops asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign mdBusy = (md_cnt_q != '0);

    // Stall counter next state: count stalled cycles, pinning at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_int && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_md_unit.sv
// Self-checking bench for hazard_md_unit: a spec-level model pushes the
// expected outputs of each cycle into a scoreboard queue, which is popped
// and compared against the DUT shortly after the inputs settle.
module tb_hazard_md_unit;

    localparam int ML = 5;
    localparam int DL = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic [1:0] Tuse_rsD, Tuse_rtD, TnewE, TnewM;
    logic       mdD, regWriteE, mdStartE, mdIsDivE, regWriteM, regWriteW;

    logic        stall, flushE, forwardAD, forwardBD, mdBusy;
    logic [1:0]  forwardAE, forwardBE;
    logic [31:0] stallCount;

    logic        stall4, flushE4, forwardAD4, forwardBD4, mdBusy4;
    logic [1:0]  forwardAE4, forwardBE4;
    logic [3:0]  stallCount4;

    typedef struct {
        logic       stall;
        logic [1:0] fae;
        logic [1:0] fbe;
        logic       fad;
        logic       fbd;
        logic       busy;
        logic [31:0] sc;
        logic [3:0]  sc4;
    } exp_t;

    exp_t sb[$];

    int          n_chk = 0;
    int          n_err = 0;
    int          m_cnt;
    logic [31:0] m_sc;
    logic [3:0]  m_sc4;

    // last observed DUT values, used for directed checks after a step
    logic        o_stall, o_flush, o_fad, o_busy;
    logic [1:0]  o_fae, o_fbe;
    logic [31:0] o_sc;
    logic [3:0]  o_sc4;
    int          busy_seen;
    int          stall_seen;

    hazard_md_unit dut (
        .clk(clk), .reset_n(reset_n),
        .rsD(rsD), .rtD(rtD), .Tuse_rsD(Tuse_rsD), .Tuse_rtD(Tuse_rtD), .mdD(mdD),
        .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE), .regWriteE(regWriteE),
        .TnewE(TnewE), .mdStartE(mdStartE), .mdIsDivE(mdIsDivE),
        .writeRegM(writeRegM), .regWriteM(regWriteM), .TnewM(TnewM),
        .writeRegW(writeRegW), .regWriteW(regWriteW),
        .stall(stall), .flushE(flushE), .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .mdBusy(mdBusy),
        .stallCount(stallCount)
    );

    hazard_md_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .rsD(rsD), .rtD(rtD), .Tuse_rsD(Tuse_rsD), .Tuse_rtD(Tuse_rtD), .mdD(mdD),
        .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE), .regWriteE(regWriteE),
        .TnewE(TnewE), .mdStartE(mdStartE), .mdIsDivE(mdIsDivE),
        .writeRegM(writeRegM), .regWriteM(regWriteM), .TnewM(TnewM),
        .writeRegW(writeRegW), .regWriteW(regWriteW),
        .stall(stall4), .flushE(flushE4), .forwardAD(forwardAD4), .forwardBD(forwardBD4),
        .forwardAE(forwardAE4), .forwardBE(forwardBE4), .mdBusy(mdBusy4),
        .stallCount(stallCount4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd_e(input logic [4:0] s);
        if (s != 0 && s == writeRegM && regWriteM && TnewM == 0) return 2'b10;
        if (s != 0 && s == writeRegW && regWriteW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_fwd_d(input logic [4:0] s);
        return s != 0 && s == writeRegM && regWriteM && TnewM == 0;
    endfunction

    function automatic logic m_hz(input logic [4:0] s, input logic [1:0] tuse);
        logic e_hz, mhz;
        e_hz = s != 0 && s == writeRegE && regWriteE && (tuse < TnewE);
        mhz  = s != 0 && s == writeRegM && regWriteM && (tuse < TnewM);
        return e_hz || mhz;
    endfunction

    function automatic exp_t model();
        exp_t e;
        e.busy  = (m_cnt != 0);
        e.stall = m_hz(rsD, Tuse_rsD) || m_hz(rtD, Tuse_rtD) ||
                  (mdD && (e.busy || mdStartE));
        e.fae   = m_fwd_e(rsE);
        e.fbe   = m_fwd_e(rtE);
        e.fad   = m_fwd_d(rsD);
        e.fbd   = m_fwd_d(rtD);
        e.sc    = m_sc;
        e.sc4   = m_sc4;
        return e;
    endfunction

    // One cycle: inputs are already driven; predict, compare, then clock the model.
    task automatic step();
        exp_t e;
        exp_t g;
        if (!reset_n) begin
            m_cnt = 0; m_sc = 0; m_sc4 = 0;
        end
        e = model();
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk("stall",      stall,       g.stall);
            chk("flushE",     flushE,      g.stall);
            chk("forwardAE",  forwardAE,   g.fae);
            chk("forwardBE",  forwardBE,   g.fbe);
            chk("forwardAD",  forwardAD,   g.fad);
            chk("forwardBD",  forwardBD,   g.fbd);
            chk("mdBusy",     mdBusy,      g.busy);
            chk("stallCount", stallCount,  g.sc);
            chk("stall_c4",   stall4,      g.stall);
            chk("flushE_c4",  flushE4,     g.stall);
            chk("fwdAE_c4",   forwardAE4,  g.fae);
            chk("fwdBE_c4",   forwardBE4,  g.fbe);
            chk("fwdAD_c4",   forwardAD4,  g.fad);
            chk("fwdBD_c4",   forwardBD4,  g.fbd);
            chk("mdBusy_c4",  mdBusy4,     g.busy);
            chk("stallCnt4",  stallCount4, g.sc4);
            o_stall = stall; o_flush = flushE; o_fad = forwardAD; o_busy = mdBusy;
            o_fae = forwardAE; o_fbe = forwardBE; o_sc = stallCount; o_sc4 = stallCount4;
            busy_seen  += int'(mdBusy);
            stall_seen += int'(stall);
            @(posedge clk);
            if (!reset_n) begin
                m_cnt = 0; m_sc = 0; m_sc4 = 0;
            end else begin
                if (mdStartE)       m_cnt = mdIsDivE ? DL : ML;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
                if (g.stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
                if (g.stall && m_sc4 != 4'hF)         m_sc4 = m_sc4 + 1;
            end
            #2;
        end
    endtask

    task automatic idle();
        rsD = 0; rtD = 0; Tuse_rsD = 0; Tuse_rtD = 0; mdD = 0;
        rsE = 0; rtE = 0; writeRegE = 0; regWriteE = 0; TnewE = 0;
        mdStartE = 0; mdIsDivE = 0;
        writeRegM = 0; regWriteM = 0; TnewM = 0;
        writeRegW = 0; regWriteW = 0;
    endtask

    task automatic reset_pulse();
        idle();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        m_cnt = 0; m_sc = 0; m_sc4 = 0;
        busy_seen = 0; stall_seen = 0;
        idle();
        reset_n = 1'b0;
        #2;
        step();
        chk("rst_busy", o_busy, 0);
        chk("rst_sc", o_sc, 0);
        reset_n = 1'b1;
        step();

        // load-use: lw $1 in E, add in D reads $1
        writeRegE = 1; regWriteE = 1; TnewE = 2; rsD = 1; Tuse_rsD = 1;
        step();
        chk("lw_E_stall", o_stall, 1);
        chk("lw_E_flush", o_flush, 1);
        // lw in M, TnewM = 1: a D-stage branch compare (Tuse 0) must still wait
        writeRegE = 0; regWriteE = 0; TnewE = 0;
        writeRegM = 1; regWriteM = 1; TnewM = 1; Tuse_rsD = 0;
        step();
        chk("lw_M_br_stall", o_stall, 1);
        Tuse_rsD = 1;
        step();
        chk("lw_M_alu_nostall", o_stall, 0);
        // value ready in M: forward into E and into the D compare
        TnewM = 0; rsE = 1; Tuse_rsD = 0;
        step();
        chk("lw_fwd_stall", o_stall, 0);
        chk("lw_fwdAE", o_fae, 2'b10);
        chk("lw_fwdAD", o_fad, 1);

        // M/W priority
        idle();
        writeRegM = 3; writeRegW = 3; regWriteM = 1; regWriteW = 1; TnewM = 0;
        rsE = 3; rtE = 3;
        step();
        chk("prio_M_AE", o_fae, 2'b10);
        chk("prio_M_BE", o_fbe, 2'b10);
        TnewM = 1;
        step();
        chk("prio_W_AE", o_fae, 2'b01);
        rsE = 0;
        step();
        chk("zero_AE", o_fae, 2'b00);

        // mult with a dependent md instruction waiting in D
        reset_pulse();
        busy_seen = 0; stall_seen = 0;
        mdD = 1; mdStartE = 1; mdIsDivE = 0;
        step();
        mdStartE = 0;
        repeat (6) step();
        chk("mult_busy_cycles", busy_seen, ML);
        chk("mult_stall_cycles", stall_seen, ML + 1);
        chk("mult_sc", o_sc, ML + 1);

        // div with no md consumer
        reset_pulse();
        busy_seen = 0; stall_seen = 0;
        mdD = 0; mdStartE = 1; mdIsDivE = 1;
        step();
        mdStartE = 0;
        repeat (11) step();
        chk("div_busy_cycles", busy_seen, DL);
        chk("div_stall_cycles", stall_seen, 0);

        // reset while the div counter sits at 4
        reset_pulse();
        mdD = 1; mdStartE = 1; mdIsDivE = 1;
        step();
        mdStartE = 0;
        repeat (6) step();
        reset_n = 1'b0;
        step();
        chk("midrst_busy", o_busy, 0);
        chk("midrst_sc", o_sc, 0);
        chk("midrst_stall", o_stall, 0);
        reset_n = 1'b1;
        step();
        chk("postrst_stall", o_stall, 0);

        // continuous stall: the narrow counter saturates
        reset_pulse();
        mdD = 1; mdStartE = 1; mdIsDivE = 0;
        repeat (20) step();
        idle();
        step();
        chk("sat_sc4", o_sc4, 15);
        chk("sat_sc32", o_sc, 20);

        // randomised mix over a small register set so matches are frequent
        for (int i = 0; i < 150; i++) begin
            rsD = 5'($urandom_range(0, 3));       rtD = 5'($urandom_range(0, 3));
            Tuse_rsD = 2'($urandom_range(0, 3));  Tuse_rtD = 2'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3));       rtE = 5'($urandom_range(0, 3));
            writeRegE = 5'($urandom_range(0, 3)); regWriteE = 1'($urandom_range(0, 1));
            TnewE = 2'($urandom_range(0, 3));
            writeRegM = 5'($urandom_range(0, 3)); regWriteM = 1'($urandom_range(0, 1));
            TnewM = 2'($urandom_range(0, 3));
            writeRegW = 5'($urandom_range(0, 3)); regWriteW = 1'($urandom_range(0, 1));
            mdD = 1'($urandom_range(0, 1));
            mdStartE = ($urandom_range(0, 7) == 0);
            mdIsDivE = 1'($urandom_range(0, 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
